// File: rtl/uart_pkg.sv
// ============================================================================
// Module      : uart_pkg
// Description : Shared UART state encodings, default width and parity helper.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_pkg;

    localparam int DATA_WIDTH_DEFAULT = 8;
    localparam int PARITY_MAX_WIDTH   = 32;

    typedef enum logic [2:0] {
        TX_IDLE   = 3'd0,
        TX_START  = 3'd1,
        TX_DATA   = 3'd2,
        TX_PARITY = 3'd3,
        TX_STOP   = 3'd4
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_IDLE   = 3'd0,
        RX_START  = 3'd1,
        RX_DATA   = 3'd2,
        RX_PARITY = 3'd3,
        RX_STOP   = 3'd4
    } rx_state_t;

    // Callers zero-extend their payload; zero bits do not disturb the XOR.
    function automatic logic calc_parity(input logic [PARITY_MAX_WIDTH-1:0] data,
                                         input logic                        odd);
        return (^data) ^ odd;
    endfunction

endpackage

`default_nettype wire

// File: rtl/uart_rx.sv
// ============================================================================
// Module      : uart_rx
// Description : UART receiver with 3-sample majority vote per bit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_rx
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_rx,
    input  logic [5:0]            i_prescale,
    input  logic                  i_par_en,
    input  logic                  i_par_typ,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_valid
);

    localparam int               BIT_W    = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_WIDTH - 1);

    rx_state_t             r_state;
    rx_state_t             w_state_nxt;
    logic [5:0]            r_cnt;
    logic [5:0]            r_prescale;
    logic [BIT_W-1:0]      r_bit;
    logic [DATA_WIDTH-1:0] r_shift;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  r_valid;
    logic                  r_par_en;
    logic                  r_par_typ;
    logic                  r_par_ok;
    logic                  r_s0;
    logic                  r_s1;
    logic [5:0]            w_mid;
    logic                  w_bit_end;
    logic                  w_sample;
    logic                  w_maj;

    assign w_mid     = {1'b0, r_prescale[5:1]};
    assign w_bit_end = (r_cnt == r_prescale - 6'd1);
    assign w_sample  = (r_cnt == w_mid + 6'd1);
    // Third vote is the live line value at the last sample point.
    assign w_maj     = (r_s0 & r_s1) | (r_s0 & i_rx) | (r_s1 & i_rx);
    assign o_data    = r_data;
    assign o_valid   = r_valid;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= RX_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            RX_IDLE: begin
                if (!i_rx) w_state_nxt = RX_START;
            end
            RX_START: begin
                if (w_sample && w_maj) w_state_nxt = RX_IDLE;
                else if (w_bit_end)    w_state_nxt = RX_DATA;
            end
            RX_DATA: begin
                if (w_bit_end && (r_bit == LAST_BIT))
                    w_state_nxt = r_par_en ? RX_PARITY : RX_STOP;
            end
            RX_PARITY: begin
                if (w_bit_end) w_state_nxt = RX_STOP;
            end
            RX_STOP: begin
                if (w_bit_end) w_state_nxt = RX_IDLE;
            end
            default: w_state_nxt = RX_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt      <= 6'd0;
            r_bit      <= '0;
            r_prescale <= 6'd0;
            r_shift    <= '0;
            r_data     <= '0;
            r_valid    <= 1'b0;
            r_par_en   <= 1'b0;
            r_par_typ  <= 1'b0;
            r_par_ok   <= 1'b1;
            r_s0       <= 1'b1;
            r_s1       <= 1'b1;
        end else if (r_state == RX_IDLE) begin
            r_cnt <= 6'd0;
            r_bit <= '0;
            if (!i_rx) begin
                r_prescale <= i_prescale;
                r_par_en   <= i_par_en;
                r_par_typ  <= i_par_typ;
                r_par_ok   <= 1'b1;
            end
        end else begin
            r_cnt <= w_bit_end ? 6'd0 : r_cnt + 6'd1;
            if (r_cnt == w_mid - 6'd1) r_s0 <= i_rx;
            if (r_cnt == w_mid)        r_s1 <= i_rx;
            if ((r_state == RX_DATA) && w_bit_end)
                r_bit <= (r_bit == LAST_BIT) ? '0 : r_bit + 1'b1;
            // Valid clears only on a confirmed start, so glitches leave outputs untouched.
            if (w_sample) begin
                case (r_state)
                    RX_START:  if (!w_maj) r_valid <= 1'b0;
                    RX_DATA:   r_shift <= {w_maj, r_shift[DATA_WIDTH-1:1]};
                    RX_PARITY: r_par_ok <= (w_maj == calc_parity(PARITY_MAX_WIDTH'(r_shift), r_par_typ));
                    RX_STOP: begin
                        if (w_maj && r_par_ok) begin
                            r_data  <= r_shift;
                            r_valid <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/uart_tx.sv
// ============================================================================
// Module      : uart_tx
// Description : UART transmitter, LSB first, optional parity, one stop bit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tx
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_valid,
    input  logic [5:0]            i_prescale,
    input  logic                  i_par_en,
    input  logic                  i_par_typ,
    output logic                  o_tx,
    output logic                  o_busy
);

    localparam int               BIT_W    = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_WIDTH - 1);

    tx_state_t             r_state;
    tx_state_t             w_state_nxt;
    logic [5:0]            r_cnt;
    logic [5:0]            r_prescale;
    logic [BIT_W-1:0]      r_bit;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  r_par_en;
    logic                  r_par_typ;
    logic                  w_bit_end;

    assign w_bit_end = (r_cnt == r_prescale - 6'd1);
    assign o_busy    = (r_state != TX_IDLE);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= TX_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        o_tx        = 1'b1;
        case (r_state)
            TX_IDLE: begin
                if (i_valid) w_state_nxt = TX_START;
            end
            TX_START: begin
                o_tx = 1'b0;
                if (w_bit_end) w_state_nxt = TX_DATA;
            end
            TX_DATA: begin
                o_tx = r_data[r_bit];
                if (w_bit_end && (r_bit == LAST_BIT))
                    w_state_nxt = r_par_en ? TX_PARITY : TX_STOP;
            end
            TX_PARITY: begin
                o_tx = calc_parity(PARITY_MAX_WIDTH'(r_data), r_par_typ);
                if (w_bit_end) w_state_nxt = TX_STOP;
            end
            TX_STOP: begin
                if (w_bit_end) w_state_nxt = TX_IDLE;
            end
            default: w_state_nxt = TX_IDLE;
        endcase
    end

    // Frame settings are captured once at the request so mid-frame input changes are harmless.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt      <= 6'd0;
            r_bit      <= '0;
            r_prescale <= 6'd0;
            r_data     <= '0;
            r_par_en   <= 1'b0;
            r_par_typ  <= 1'b0;
        end else if (r_state == TX_IDLE) begin
            r_cnt <= 6'd0;
            r_bit <= '0;
            if (i_valid) begin
                r_prescale <= i_prescale;
                r_data     <= i_data;
                r_par_en   <= i_par_en;
                r_par_typ  <= i_par_typ;
            end
        end else begin
            r_cnt <= w_bit_end ? 6'd0 : r_cnt + 6'd1;
            if ((r_state == TX_DATA) && w_bit_end)
                r_bit <= (r_bit == LAST_BIT) ? '0 : r_bit + 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/uart_top.sv
// ============================================================================
// Module      : uart_top
// Description : Full-duplex UART: independent transmitter and receiver.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_top
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] TX_IN_P,
    input  logic                  TX_IN_V,
    input  logic                  RX_IN_S,
    input  logic [5:0]            prescale,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic                  TX_OUT_S,
    output logic                  TX_OUT_V,
    output logic [DATA_WIDTH-1:0] RX_OUT_P,
    output logic                  RX_OUT_V
);

    uart_tx #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_tx (
        .i_clk      (CLK),
        .i_rst_n    (RST),
        .i_data     (TX_IN_P),
        .i_valid    (TX_IN_V),
        .i_prescale (prescale),
        .i_par_en   (PAR_EN),
        .i_par_typ  (PAR_TYP),
        .o_tx       (TX_OUT_S),
        .o_busy     (TX_OUT_V)
    );

    uart_rx #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_rx (
        .i_clk      (CLK),
        .i_rst_n    (RST),
        .i_rx       (RX_IN_S),
        .i_prescale (prescale),
        .i_par_en   (PAR_EN),
        .i_par_typ  (PAR_TYP),
        .o_data     (RX_OUT_P),
        .o_valid    (RX_OUT_V)
    );

endmodule

`default_nettype wire

// File: tb/tb_uart_top.sv
// ============================================================================
// Module      : tb_uart_top
// Description : Directed self-checking bench for uart_top with bit/byte scoreboards.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_top;

    logic       CLK = 1'b0;
    logic       RST;
    logic [7:0] TX_IN_P;
    logic       TX_IN_V;
    logic       RX_IN_S;
    logic [5:0] prescale;
    logic       PAR_EN;
    logic       PAR_TYP;
    logic       TX_OUT_S;
    logic       TX_OUT_V;
    logic [7:0] RX_OUT_P;
    logic       RX_OUT_V;

    int         checks = 0;
    int         errors = 0;
    logic       tx_q[$];
    logic [7:0] rx_q[$];
    logic [7:0] last_good = 8'h00;

    uart_top #(
        .DATA_WIDTH (8)
    ) dut (
        .CLK      (CLK),
        .RST      (RST),
        .TX_IN_P  (TX_IN_P),
        .TX_IN_V  (TX_IN_V),
        .RX_IN_S  (RX_IN_S),
        .prescale (prescale),
        .PAR_EN   (PAR_EN),
        .PAR_TYP  (PAR_TYP),
        .TX_OUT_S (TX_OUT_S),
        .TX_OUT_V (TX_OUT_V),
        .RX_OUT_P (RX_OUT_P),
        .RX_OUT_V (RX_OUT_V)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at a falling edge; returns at the falling edge of the first idle cycle.
    task automatic tx_send(input logic [7:0] d, input logic pe, input logic pt, input logic [5:0] ps);
        int   nb;
        logic b;
        tx_q.push_back(1'b0);
        for (int i = 0; i < 8; i++) tx_q.push_back(d[i]);
        if (pe) tx_q.push_back((^d) ^ pt);
        tx_q.push_back(1'b1);
        prescale = ps;
        PAR_EN   = pe;
        PAR_TYP  = pt;
        TX_IN_P  = d;
        TX_IN_V  = 1'b1;
        @(negedge CLK);
        TX_IN_V = 1'b0;
        nb = tx_q.size();
        for (int k = 0; k < nb; k++) begin
            b = tx_q.pop_front();
            for (int c = 0; c < int'(ps); c++) begin
                check("tx_line", {31'd0, TX_OUT_S}, {31'd0, b});
                check("tx_busy", {31'd0, TX_OUT_V}, 32'd1);
                // A busy-time request and a prescale change must not disturb the frame.
                if (k == 3 && c == 1) begin
                    TX_IN_V  = 1'b1;
                    TX_IN_P  = ~d;
                    prescale = (ps == 6'd8) ? 6'd16 : 6'd8;
                end else if (k == 3 && c == 2) begin
                    TX_IN_V = 1'b0;
                end
                @(negedge CLK);
            end
        end
        prescale = ps;
        check("tx_idle_line", {31'd0, TX_OUT_S}, 32'd1);
        check("tx_idle_busy", {31'd0, TX_OUT_V}, 32'd0);
    endtask

    task automatic rx_frame(input logic [7:0] d, input logic pe, input logic pt,
                            input logic bad_par, input logic stop_b, input logic [5:0] ps);
        logic       bits[$];
        logic [7:0] exp;
        prescale = ps;
        PAR_EN   = pe;
        PAR_TYP  = pt;
        bits.push_back(1'b0);
        for (int i = 0; i < 8; i++) bits.push_back(d[i]);
        if (pe) bits.push_back((^d) ^ pt ^ bad_par);
        bits.push_back(stop_b);
        if (stop_b && !bad_par) rx_q.push_back(d);
        foreach (bits[k]) begin
            if (k == 2) check("rx_valid_clear", {31'd0, RX_OUT_V}, 32'd0);
            RX_IN_S = bits[k];
            repeat (int'(ps)) @(negedge CLK);
        end
        RX_IN_S = 1'b1;
        repeat (int'(ps)) @(negedge CLK);
        if (rx_q.size() != 0) begin
            exp = rx_q.pop_front();
            check("rx_data", {24'd0, RX_OUT_P}, {24'd0, exp});
            check("rx_valid", {31'd0, RX_OUT_V}, 32'd1);
            last_good = exp;
        end else begin
            check("rx_bad_valid", {31'd0, RX_OUT_V}, 32'd0);
            check("rx_bad_data", {24'd0, RX_OUT_P}, {24'd0, last_good});
        end
    endtask

    initial begin
        RST      = 1'b0;
        TX_IN_P  = 8'h00;
        TX_IN_V  = 1'b0;
        RX_IN_S  = 1'b1;
        prescale = 6'd8;
        PAR_EN   = 1'b0;
        PAR_TYP  = 1'b0;
        repeat (3) @(negedge CLK);
        check("rst_tx_line", {31'd0, TX_OUT_S}, 32'd1);
        check("rst_tx_busy", {31'd0, TX_OUT_V}, 32'd0);
        check("rst_rx_data", {24'd0, RX_OUT_P}, 32'd0);
        check("rst_rx_valid", {31'd0, RX_OUT_V}, 32'd0);
        RST = 1'b1;
        @(negedge CLK);

        tx_send(8'h5A, 1'b0, 1'b0, 6'd8);
        repeat (3) @(negedge CLK);
        tx_send(8'h5A, 1'b1, 1'b0, 6'd16);
        tx_send(8'h5A, 1'b1, 1'b1, 6'd16);

        rx_frame(8'h5D, 1'b0, 1'b0, 1'b0, 1'b1, 6'd8);
        rx_frame(8'h3C, 1'b1, 1'b0, 1'b0, 1'b1, 6'd8);
        rx_frame(8'h5D, 1'b1, 1'b0, 1'b1, 1'b1, 6'd8);
        rx_frame(8'h5D, 1'b0, 1'b0, 1'b0, 1'b0, 6'd8);
        rx_frame(8'h81, 1'b1, 1'b1, 1'b0, 1'b1, 6'd16);

        prescale = 6'd8;
        PAR_EN   = 1'b0;
        RX_IN_S  = 1'b0;
        repeat (2) @(negedge CLK);
        RX_IN_S = 1'b1;
        repeat (16) @(negedge CLK);
        check("glitch_valid", {31'd0, RX_OUT_V}, 32'd1);
        check("glitch_data", {24'd0, RX_OUT_P}, 32'h81);
        rx_frame(8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, 6'd8);

        TX_IN_P = 8'hC3;
        TX_IN_V = 1'b1;
        @(negedge CLK);
        TX_IN_V = 1'b0;
        repeat (30) @(negedge CLK);
        check("pre_rst_busy", {31'd0, TX_OUT_V}, 32'd1);
        check("pre_rst_line", {31'd0, TX_OUT_S}, 32'd0);
        #1 RST = 1'b0;
        #1;
        check("mid_rst_line", {31'd0, TX_OUT_S}, 32'd1);
        check("mid_rst_busy", {31'd0, TX_OUT_V}, 32'd0);
        check("mid_rst_rx_data", {24'd0, RX_OUT_P}, 32'd0);
        check("mid_rst_rx_valid", {31'd0, RX_OUT_V}, 32'd0);
        last_good = 8'h00;
        @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        tx_send(8'hA5, 1'b0, 1'b0, 6'd8);
        tx_send(8'h00, 1'b1, 1'b1, 6'd32);
        rx_frame(8'h7E, 1'b0, 1'b0, 1'b0, 1'b1, 6'd32);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
